// File: rtl/z_buffer_mem.sv
// z_buffer_mem: on-chip depth store serving single-beat Z reads/writes from the
// depth-test unit, addressed relative to a programmable base, with a hardware
// bulk-clear sweep that fills every entry with the maximum depth (all ones).
module z_buffer_mem #(
  parameter int unsigned Z_SIZE       = 8,
  parameter int unsigned X_RES        = 4,
  parameter int unsigned Y_RES        = 4,
  parameter int unsigned ADDR_SIZE    = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE-1:0] buffer_base_address_i,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  input  logic                 clear_i,
  output logic                 clear_done_o,
  output logic                 busy_o,
  output logic                 addr_err_o
);

  localparam int unsigned DEPTH = X_RES * Y_RES;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RD_RESP  = 3'd2;
  localparam logic [2:0] S_WR_ACK   = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;
  localparam logic [2:0] S_CLR_DONE = 3'd5;

  logic [Z_SIZE-1:0] mem [DEPTH];

  logic [2:0]           state_q, state_d;
  logic [3:0]           lat_q, lat_d;
  logic [AW-1:0]        sweep_q, sweep_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 oor_q, oor_d;

  logic [Z_SIZE-1:0]    buf_data_r_q;
  logic                 data_r_valid_q;
  logic                 data_w_ready_q;
  logic                 clear_done_q;
  logic                 busy_q;
  logic                 addr_err_q;

  logic [ADDR_SIZE-1:0] index_s;
  logic                 in_range_s;
  logic                 mem_we_s;
  logic [AW-1:0]        mem_waddr_s;
  logic [Z_SIZE-1:0]    mem_wdata_s;
  logic                 set_err_s;
  logic [Z_SIZE-1:0]    rd_data_s;

  // Unsigned wrap makes addresses below the base look huge, hence out of range.
  assign index_s    = buf_addr - buffer_base_address_i;
  assign in_range_s = (index_s < ADDR_SIZE'(DEPTH));

  // Next-state, memory write port and request capture.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    sweep_d     = sweep_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = sweep_q;
    mem_wdata_s = {Z_SIZE{1'b1}};
    set_err_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          sweep_d = '0;
          state_d = S_CLEAR;
        end else if (buf_r_w && data_r_ready) begin
          idx_d = index_s[AW-1:0];
          oor_d = !in_range_s;
          lat_d = 4'(READ_LATENCY - 1);
          // With a latency of one the response cycle directly follows acceptance.
          if (READ_LATENCY <= 1) begin
            state_d = S_RD_RESP;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else if (!buf_r_w && data_w_valid) begin
          mem_we_s    = in_range_s;
          mem_waddr_s = index_s[AW-1:0];
          mem_wdata_s = buf_data_w;
          set_err_s   = !in_range_s;
          state_d     = S_WR_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        // Leave one count early so the registered response lands on the
        // READ_LATENCY-th cycle after acceptance.
        if (lat_q <= 4'd1) begin
          lat_d   = 4'd0;
          state_d = S_RD_RESP;
        end else begin
          lat_d   = lat_q - 4'd1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_RESP: state_d = S_IDLE;
      S_WR_ACK:  state_d = S_IDLE;
      S_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = sweep_q;
        sweep_d     = sweep_q + {{(AW-1){1'b0}}, 1'b1};
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d = S_CLR_DONE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_CLR_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Read data for the response being launched this edge.
  always_comb begin
    if (oor_d) begin
      rd_data_s = {Z_SIZE{1'b1}};
    end else begin
      rd_data_s = mem[idx_d];
    end
  end

  // Storage array; contents survive reset, but no write lands on a reset edge.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !rst_i) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      lat_q          <= 4'd0;
      sweep_q        <= '0;
      idx_q          <= '0;
      oor_q          <= 1'b0;
      buf_data_r_q   <= '0;
      data_r_valid_q <= 1'b0;
      data_w_ready_q <= 1'b0;
      clear_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      sweep_q        <= sweep_d;
      idx_q          <= idx_d;
      oor_q          <= oor_d;
      data_r_valid_q <= (state_d == S_RD_RESP);
      data_w_ready_q <= (state_d == S_WR_ACK);
      clear_done_q   <= (state_d == S_CLR_DONE);
      busy_q         <= (state_d != S_IDLE);
      if (state_d == S_RD_RESP) begin
        buf_data_r_q <= rd_data_s;
      end
      if (set_err_s || ((state_d == S_RD_RESP) && oor_d)) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign buf_data_r   = buf_data_r_q;
  assign data_r_valid = data_r_valid_q;
  assign data_w_ready = data_w_ready_q;
  assign clear_done_o = clear_done_q;
  assign busy_o       = busy_q;
  assign addr_err_o   = addr_err_q;

endmodule
